// File: rtl/bsg_wormhole_inject_arbiter.sv
// Round-robin injection arbiter for one wormhole router link. The grant is locked for the whole packet.
// Optional per-requester header counters are built in when BSG_WORMHOLE_INJECT_ARBITER_STATS_EN is defined.
module bsg_wormhole_inject_arbiter #(
  parameter int num_in_p     = 4,
  parameter int flit_width_p = 32,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_in_p-1:0]              v_i,
  input  logic [num_in_p*flit_width_p-1:0] data_i,
  output logic [num_in_p-1:0]              ready_and_o,
  output logic                             v_o,
  output logic [flit_width_p-1:0]          data_o,
  input  logic                             ready_and_i,
  output logic [num_in_p-1:0]              grant_o,
`ifdef BSG_WORMHOLE_INJECT_ARBITER_STATS_EN
  output logic [num_in_p*16-1:0]           pkt_count_o,
  input  logic                             clear_stats_i,
`endif
  output logic                             busy_o
);

  localparam int ptr_w_lp = $clog2(num_in_p);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [ptr_w_lp-1:0]     ptr_q, ptr_d;
  logic [ptr_w_lp-1:0]     owner_q, owner_d;
  logic [len_width_p-1:0]  cnt_q, cnt_d;

  logic [ptr_w_lp-1:0]     winner, winner_inc, owner_idx, cand;
  logic                    found, has_owner, xfer, hdr_xfer;
  logic [len_width_p-1:0]  hdr_len;

  // Scan from ptr_q upward (modulo num_in_p); the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < num_in_p; k++) begin
      cand = ptr_w_lp'((int'(ptr_q) + k) % num_in_p);
      if (!found && v_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign winner_inc = (winner == ptr_w_lp'(num_in_p - 1)) ? '0 : winner + 1'b1;

  // Reset gates the combinational grant so outputs drop at once while reset_n_i is low.
  assign owner_idx = (state_q == BUSY) ? owner_q : winner;
  assign has_owner = reset_n_i & ((state_q == BUSY) | found);

  always_comb begin
    grant_o = '0;
    if (has_owner) grant_o[owner_idx] = 1'b1;
  end

  assign data_o      = data_i[owner_idx*flit_width_p +: flit_width_p];
  assign v_o         = has_owner & v_i[owner_idx];
  assign ready_and_o = {num_in_p{ready_and_i}} & grant_o;
  assign busy_o      = (state_q == BUSY);

  assign xfer     = v_o & ready_and_i;
  assign hdr_xfer = xfer & (state_q == IDLE);
  assign hdr_len  = data_o[len_offset_p +: len_width_p];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          ptr_d = winner_inc;
          if (hdr_len != '0) begin
            state_d = BUSY;
            cnt_d   = hdr_len;
            owner_d = winner;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == len_width_p'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

`ifdef BSG_WORMHOLE_INJECT_ARBITER_STATS_EN
  logic [num_in_p-1:0][15:0] pkt_cnt_q, pkt_cnt_d;

  // Clear wins over a same-cycle header; counters saturate at all-ones.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (clear_stats_i) begin
      pkt_cnt_d = '0;
    end else if (hdr_xfer && (pkt_cnt_q[winner] != 16'hFFFF)) begin
      pkt_cnt_d[winner] = pkt_cnt_q[winner] + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pkt_cnt_q <= '0;
    else            pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_count_o = pkt_cnt_q;
`endif

endmodule
